sdio_cmd_phy_gen2: RTL and testbench

Second-generation SDIO device command-line PHY. It deserialises host commands (48-bit frames) on the CMD line and checks their CRC7 and end bit. It then serialises device responses of parametrised maximum length, up to 136-bit R2, with selectable CRC handling, a minimum NCR turnaround and a response timeout. It sits between the SDIO pad (CMD in/out/dir) and the command/response data-link layer, alongside the data PHY.

---
 rtl/sdio_cmd_phy_gen2.sv | 211 +++++++++++++++++++++
 tb/tb_sdio_cmd_phy_gen2.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_phy_gen2.sv
// sdio_cmd_phy_gen2: SDIO device CMD-line PHY.
// Receives 48-bit host commands, serialises responses.
module sdio_cmd_phy_gen2 #(
  parameter int RSP_MAX_BITS = 136,
  parameter int LEN_W        = 8,
  parameter int NCR_MIN      = 2,
  parameter int RSP_TIMEOUT  = 64
) (
  input  logic                    i_sdio_clk,
  input  logic                    rst_n,
  output logic                    o_cmd_phy_idle,
  output logic                    o_cmd_stb,
  output logic [5:0]              o_cmd,
  output logic [31:0]             o_cmd_arg,
  output logic                    o_cmd_crc_good,
  output logic                    o_cmd_end_err,
  input  logic                    i_rsps_stb,
  input  logic [RSP_MAX_BITS-1:0] i_rsps,
  input  logic [LEN_W-1:0]        i_rsps_len,
  input  logic [1:0]              i_rsps_crc_mode,
  input  logic                    i_rsps_fail,
  output logic                    o_rsps_idle,
  output logic                    o_rsps_done,
  output logic                    o_rsps_timeout,
  output logic                    o_sdio_cmd_dir,
  input  logic                    i_sdio_cmd_in,
  output logic                    o_sdio_cmd_out
);

  localparam int WW = $clog2(RSP_TIMEOUT + 2);
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(RSP_MAX_BITS);
  localparam logic [WW-1:0] TMO = WW'(RSP_TIMEOUT);
  localparam logic [WW-1:0] NCR1 =
    WW'(NCR_MIN > 0 ? NCR_MIN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_RX, S_CMD_DONE, S_WAIT,
    S_TX, S_CRC, S_END, S_REL
  } state_t;

  state_t state_q, state_d;

  logic [5:0]              bit_q;
  logic [45:0]             rx_q;
  logic [6:0]              crc_q;
  logic [WW-1:0]           wcnt_q;
  logic [LEN_W-1:0]        cnt_q, len_q;
  logic [RSP_MAX_BITS-1:0] rsp_q;
  logic [1:0]              mode_q;
  logic                    vld_q;
  logic [5:0]              cmd_q;
  logic [31:0]             arg_q;
  logic                    good_q, eerr_q, done_q;

  logic [LEN_W-1:0] len_in, len_e;
  logic [1:0]       mode_in, mode_e;
  logic             have, ncr_ok;

  function automatic logic [6:0] crc7(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  assign len_in  = (i_rsps_len > MAXL) ? MAXL : i_rsps_len;
  assign mode_in = (i_rsps_crc_mode == 2'd3) ? 2'd0
                                             : i_rsps_crc_mode;
  assign len_e   = i_rsps_stb ? len_in : len_q;
  assign mode_e  = i_rsps_stb ? mode_in : mode_q;
  assign have    = vld_q | i_rsps_stb;
  assign ncr_ok  = wcnt_q >= NCR1;

  assign o_cmd_phy_idle = (state_q == S_IDLE) & i_sdio_cmd_in;
  assign o_rsps_idle    = (state_q == S_IDLE);
  assign o_cmd_stb      = (state_q == S_CMD_DONE) & ~i_rsps_fail;
  assign o_rsps_timeout = (state_q == S_WAIT) & ~have &
                          (wcnt_q == TMO) & ~i_rsps_fail;
  assign o_rsps_done    = done_q;
  assign o_cmd          = cmd_q;
  assign o_cmd_arg      = arg_q;
  assign o_cmd_crc_good = good_q;
  assign o_cmd_end_err  = eerr_q;

  // State register.
  always_ff @(posedge i_sdio_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and pad drive.
  always_comb begin
    state_d        = state_q;
    o_sdio_cmd_dir = 1'b0;
    o_sdio_cmd_out = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!i_sdio_cmd_in) state_d = S_CMD_RX;
      end
      S_CMD_RX: begin
        if (bit_q == 6'd47)
          state_d = rx_q[45] ? S_CMD_DONE : S_IDLE;
      end
      S_CMD_DONE: begin
        state_d = (good_q && !eerr_q) ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        o_sdio_cmd_dir = 1'b1;
        if (have && ncr_ok) begin
          if (len_e != '0)         state_d = S_TX;
          else if (mode_e == 2'd2) state_d = S_END;
          else                     state_d = S_CRC;
        end else if (wcnt_q == TMO) begin
          state_d = S_IDLE;
        end
      end
      S_TX: begin
        o_sdio_cmd_dir = 1'b1;
        o_sdio_cmd_out = rsp_q[RSP_MAX_BITS-1];
        if (cnt_q == len_q - 1'b1)
          state_d = (mode_q == 2'd2) ? S_END : S_CRC;
      end
      S_CRC: begin
        o_sdio_cmd_dir = 1'b1;
        o_sdio_cmd_out = (mode_q == 2'd1) | crc_q[6];
        if (cnt_q == LEN_W'(6)) state_d = S_END;
      end
      S_END: begin
        o_sdio_cmd_dir = 1'b1;
        state_d        = S_REL;
      end
      S_REL: begin
        o_sdio_cmd_dir = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_rsps_fail && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Frame capture, response shifting, counters and CRC.
  always_ff @(posedge i_sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q  <= '0;
      rx_q   <= '0;
      crc_q  <= '0;
      wcnt_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      rsp_q  <= '0;
      mode_q <= '0;
      vld_q  <= 1'b0;
      cmd_q  <= '0;
      arg_q  <= '0;
      good_q <= 1'b0;
      eerr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_REL) & ~i_rsps_fail;
      unique case (state_q)
        S_IDLE: begin
          bit_q <= 6'd1;
          crc_q <= '0;
          vld_q <= 1'b0;
        end
        S_CMD_RX: begin
          bit_q <= bit_q + 6'd1;
          rx_q  <= {rx_q[44:0], i_sdio_cmd_in};
          if (bit_q < 6'd40)
            crc_q <= crc7(crc_q, i_sdio_cmd_in);
          if (bit_q == 6'd47 && rx_q[45]) begin
            cmd_q  <= rx_q[44:39];
            arg_q  <= rx_q[38:7];
            good_q <= (rx_q[6:0] == crc_q);
            eerr_q <= ~i_sdio_cmd_in;
          end
        end
        S_CMD_DONE: begin
          wcnt_q <= WW'(1);
          crc_q  <= '0;
          vld_q  <= 1'b0;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q + WW'(1);
          cnt_q  <= '0;
          crc_q  <= '0;
          if (i_rsps_stb) begin
            rsp_q  <= i_rsps;
            len_q  <= len_in;
            mode_q <= mode_in;
            vld_q  <= 1'b1;
          end
        end
        S_TX: begin
          rsp_q <= rsp_q << 1;
          crc_q <= crc7(crc_q, rsp_q[RSP_MAX_BITS-1]);
          if (cnt_q == len_q - 1'b1) cnt_q <= '0;
          else                      cnt_q <= cnt_q + 1'b1;
        end
        S_CRC: begin
          crc_q <= {crc_q[5:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdio_cmd_phy_gen2.sv
// tb_sdio_cmd_phy_gen2: scoreboard bench for the CMD PHY.
// Expected commands/frames queued at drive, checked at pad.
module tb_sdio_cmd_phy_gen2;

  localparam int RMB = 136;
  localparam int NCR = 2;
  localparam int TMO = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_phy_idle, cmd_stb;
  logic [5:0]       cmd;
  logic [31:0]      cmd_arg;
  logic             crc_good, end_err;
  logic             rsps_stb;
  logic [RMB-1:0]   rsps;
  logic [7:0]       rsps_len;
  logic [1:0]       rsps_mode;
  logic             rsps_fail;
  logic             rsps_idle, rsps_done, rsps_tmo;
  logic             cmd_dir, cmd_in, cmd_out;

  sdio_cmd_phy_gen2 dut (
    .i_sdio_clk      (clk),
    .rst_n           (rst_n),
    .o_cmd_phy_idle  (cmd_phy_idle),
    .o_cmd_stb       (cmd_stb),
    .o_cmd           (cmd),
    .o_cmd_arg       (cmd_arg),
    .o_cmd_crc_good  (crc_good),
    .o_cmd_end_err   (end_err),
    .i_rsps_stb      (rsps_stb),
    .i_rsps          (rsps),
    .i_rsps_len      (rsps_len),
    .i_rsps_crc_mode (rsps_mode),
    .i_rsps_fail     (rsps_fail),
    .o_rsps_idle     (rsps_idle),
    .o_rsps_done     (rsps_done),
    .o_rsps_timeout  (rsps_tmo),
    .o_sdio_cmd_dir  (cmd_dir),
    .i_sdio_cmd_in   (cmd_in),
    .o_sdio_cmd_out  (cmd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        good;
    logic        eerr;
  } cmd_t;

  typedef struct {
    logic [159:0] bits;
    int           n;
    int           cut;
  } rsp_t;

  cmd_t cq[$];
  rsp_t rq[$];
  cmd_t ce;
  rsp_t cur;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, stb_cyc = 0;
  int n_stb = 0, n_done = 0, n_tmo = 0;
  int cap_n = 0, ph = 0;
  logic cap = 1'b0, nx_cmd = 1'b0, nx_good = 1'b0;
  logic nx_tmo = 1'b0;
  logic [159:0] got;

  task automatic chk(input string tag,
                     input logic [159:0] got_v,
                     input logic [159:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got_v, exp_v);
    end
  endtask

  function automatic logic [6:0] crc7f(
    input logic [135:0] d,
    input int           n
  );
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 0; i < n; i++) begin
      fb = d[135-i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [39:0] h);
    return {h, crc7f({h, 96'h0}, 40), 1'b1};
  endfunction

  always @(posedge clk) cyc++;

  // Pad monitor: pops expectations as the DUT produces output.
  always @(negedge clk) begin
    if (!rst_n) begin
      cap = 1'b0; ph = 0; nx_cmd = 1'b0; nx_tmo = 1'b0;
    end else begin
      if (rsps_done) n_done++;
      if (nx_cmd) begin
        chk("dir_after_stb", {cmd_dir, rsps_idle},
            nx_good ? 2'b10 : 2'b01);
        nx_cmd = 1'b0;
      end
      if (nx_tmo) begin
        chk("tmo_dir", cmd_dir, 0);
        nx_tmo = 1'b0;
      end
      if (cmd_stb) begin
        n_stb++;
        stb_cyc = cyc;
        chk("cmd_q_nonempty", cq.size() != 0, 1);
        if (cq.size() != 0) begin
          ce = cq.pop_front();
          chk("cmd_idx", cmd, ce.cmd);
          chk("cmd_arg", cmd_arg, ce.arg);
          chk("crc_good", crc_good, ce.good);
          chk("end_err", end_err, ce.eerr);
          nx_cmd  = 1'b1;
          nx_good = ce.good & ~ce.eerr;
        end
      end
      if (rsps_tmo) begin
        n_tmo++;
        chk("tmo_cycle", cyc - stb_cyc, TMO);
        nx_tmo = 1'b1;
      end
      if (ph == 2) begin
        chk("rel_done", {cmd_dir, rsps_done}, 2'b01);
        ph = 0;
      end else if (ph == 1) begin
        chk("rel_line", {cmd_dir, cmd_out}, 2'b11);
        ph = 2;
      end else if (cap) begin
        if (!cmd_dir) begin
          chk("cut_len", cap_n, cur.cut);
          chk("cut_bits", got, cur.bits >> (cur.n - cap_n));
          cap = 1'b0;
        end else begin
          got = {got[158:0], cmd_out};
          cap_n++;
          if (cap_n == cur.n) begin
            cap = 1'b0;
            if (cur.cut != 0) begin
              chk("cut_len", cap_n, cur.cut);
            end else begin
              chk("rsp_bits", got, cur.bits);
              ph = 1;
            end
          end
        end
      end else if (cmd_dir && !cmd_out) begin
        chk("rsp_q_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) begin
          cur   = rq.pop_front();
          got   = '0;
          cap_n = 1;
          cap   = 1'b1;
          chk("ncr_min", (cyc - stb_cyc) >= NCR, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [47:0] f);
    cmd_t e;
    if (f[46]) begin
      e.cmd  = f[45:40];
      e.arg  = f[39:8];
      e.good = (f[7:1] == crc7f({f[47:8], 96'h0}, 40));
      e.eerr = ~f[0];
      cq.push_back(e);
    end
    for (int i = 47; i >= 0; i--) begin
      cmd_in = f[i];
      tick();
    end
    cmd_in = 1'b1;
  endtask

  task automatic rsp(input logic [135:0] p, input int len,
                     input logic [1:0] md, input int cut,
                     input int dly);
    rsp_t e;
    int L;
    logic [1:0] m;
    logic [159:0] v;
    L = (len > RMB) ? RMB : len;
    m = (md == 2'd3) ? 2'd0 : md;
    v = '0;
    for (int i = 0; i < L; i++) v = {v[158:0], p[RMB-1-i]};
    if (m == 2'd0)      v = {v[152:0], crc7f(p, L)};
    else if (m == 2'd1) v = {v[152:0], 7'h7F};
    v = {v[158:0], 1'b1};
    e.bits = v;
    e.n    = (m == 2'd2) ? L + 1 : L + 8;
    e.cut  = cut;
    repeat (dly) tick();
    rq.push_back(e);
    rsps_stb  = 1'b1;
    rsps      = p;
    rsps_len  = len[7:0];
    rsps_mode = md;
    tick();
    rsps_stb = 1'b0;
  endtask

  task automatic settle(input int lim);
    int k = 0;
    while (!rsps_idle && k < lim) begin
      tick();
      k++;
    end
    chk("settle", k < lim, 1);
    repeat (3) tick();
  endtask

  initial begin
    logic [135:0] r;
    int d0, s0, k;
    cmd_in = 1'b1; rsps_stb = 1'b0; rsps = '0;
    rsps_len = '0; rsps_mode = '0; rsps_fail = 1'b0;
    repeat (3) tick();
    chk("rst_ctl",
        {cmd_dir, cmd_out, cmd_stb, rsps_done, rsps_tmo,
         rsps_idle, cmd_phy_idle, crc_good, end_err},
        9'b0_1_000_11_00);
    chk("rst_data", {cmd, cmd_arg}, 38'h0);
    rst_n = 1'b1;
    tick();

    // CMD0, no response request: timeout path.
    send_cmd(48'h400000000095);
    settle(200);
    chk("n_tmo", n_tmo, 1);

    // CMD8 with R7, mode 0.
    send_cmd(48'h48000001AA87);
    d0 = n_done;
    rsp({40'h08000001AA, 96'h0}, 40, 2'd0, 0, 2);
    settle(200);
    chk("r7_done", n_done - d0, 1);
    chk("r7_dir", cmd_dir, 0);

    // CMD0 with a corrupted CRC byte.
    s0 = n_stb;
    send_cmd(48'h400000000097);
    settle(200);
    chk("bad_stb", n_stb - s0, 1);
    chk("bad_no_tmo", n_tmo, 1);

    // CMD2 with R2: 136 bits, no CRC, earliest turnaround.
    r = {8'h00, $urandom, $urandom, $urandom, $urandom};
    r[133:128] = 6'h3F;
    send_cmd(mk_frame(40'h4200000000));
    rsp(r, 136, 2'd2, 0, 1);
    settle(400);

    // R3-style response with fixed 7F CRC field.
    send_cmd(mk_frame(40'h4100000000));
    rsp({40'h3F00FF8000, 96'h0}, 40, 2'd1, 0, 2);
    settle(200);

    // Empty payload, reserved mode behaves as generated CRC.
    send_cmd(mk_frame(40'h4700000000));
    rsp({8'h00, $urandom, $urandom, $urandom, $urandom},
        0, 2'd3, 0, 3);
    settle(200);

    // Over-long length clamps to the full 136 bits.
    send_cmd(mk_frame(40'h4A00000000));
    rsp({8'h00, $urandom, $urandom, $urandom, $urandom},
        200, 2'd2, 0, 2);
    settle(400);

    // Device-to-host direction bit: frame is dropped.
    s0 = n_stb;
    send_cmd(48'h050000000001);
    settle(100);
    chk("dir0_no_stb", n_stb - s0, 0);
    chk("dir0_idle", rsps_idle, 1);

    // Abort while bit 20 of the payload is on the line.
    send_cmd(48'h48000001AA87);
    d0 = n_done;
    rsp({40'h08000001AA, 96'h0}, 40, 2'd0, 21, 2);
    k = 0;
    while (!(cap && cap_n == 20) && k < 200) begin
      tick();
      k++;
    end
    chk("fail_wait", k < 200, 1);
    rsps_fail = 1'b1;
    tick();
    rsps_fail = 1'b0;
    settle(50);
    chk("fail_no_done", n_done - d0, 0);
    chk("fail_dir", cmd_dir, 0);

    // Reset in the middle of a command frame.
    for (int i = 47; i >= 28; i--) begin
      cmd_in = k[0] ^ (i == 47 ? 1'b0 : 1'b1) ? 1'b1 : 1'b0;
      cmd_in = (i == 47) ? 1'b0 : 1'b1;
      tick();
    end
    cmd_in = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_ctl",
        {cmd_dir, cmd_out, cmd_stb, rsps_done, rsps_tmo,
         rsps_idle, cmd_phy_idle, crc_good, end_err},
        9'b0_1_000_11_00);
    chk("mid_rst_data", {cmd, cmd_arg}, 38'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    s0 = n_stb;
    send_cmd(48'h48000001AA87);
    tick();
    rsps_fail = 1'b1;
    tick();
    rsps_fail = 1'b0;
    settle(50);
    chk("post_rst_stb", n_stb - s0, 1);
    chk("post_rst_tmo", n_tmo, 1);

    chk("cmd_q_empty", cq.size(), 0);
    chk("rsp_q_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
